// File: rtl/dmem_arbiter_if.sv
// Bundles the pipeline MEM-stage port, the DMA port and the RAM port of dmem_arbiter.
// The arbiter takes the slave modport; the requesters/RAM side takes the master modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Pipeline MEM stage
  logic              p_rd;
  logic              p_wr;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;
  logic              p_rvalid;
  logic              p_stall;
  // Host/loader DMA
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  // Single-port synchronous RAM
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p_rd, p_wr, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output p_rdata, p_rvalid, p_stall, d_ack, d_rdata, d_rvalid,
           mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output p_rd, p_wr, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  p_rdata, p_rvalid, p_stall, d_ack, d_rdata, d_rvalid,
           mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline MEM stage (fixed priority) vs. host DMA port on one 1-cycle RAM.
// Optional DMA anti-starvation counter enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_P = 2'd1,
    RD_D = 2'd2
  } state_e;

  if (STARVE_MAX < 1) begin : g_param_check
    $error("dmem_arbiter: STARVE_MAX must be at least 1");
  end

  state_e            state_q, state_d;
  logic              pipe_req;
  logic              starve_hit;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] p_rdata;
  logic [DATA_W-1:0] d_rdata;
  logic              p_rvalid;
  logic              d_rvalid;
  logic              p_stall;
  logic              d_ack;

  assign pipe_req = bus.p_rd | bus.p_wr;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    p_rdata   = '0;
    d_rdata   = '0;
    p_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    p_stall   = 1'b0;
    d_ack     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.d_req && (!pipe_req || starve_hit)) begin
          d_ack    = 1'b1;
          p_stall  = pipe_req;
          mem_addr = bus.d_addr;
          if (bus.d_we) begin
            mem_we    = 1'b1;
            mem_wdata = bus.d_wdata;
          end else begin
            mem_re  = 1'b1;
            state_d = RD_D;
          end
        end else if (pipe_req) begin
          mem_addr = bus.p_addr;
          // p_rd together with p_wr is illegal; the write takes precedence.
          if (bus.p_wr) begin
            mem_we    = 1'b1;
            mem_wdata = bus.p_wdata;
          end else begin
            mem_re  = 1'b1;
            p_stall = 1'b1;
            state_d = RD_P;
          end
        end
      end
      RD_P: begin
        p_rvalid = 1'b1;
        p_rdata  = bus.mem_rdata;
        state_d  = IDLE;
      end
      RD_D: begin
        d_rvalid = 1'b1;
        d_rdata  = bus.mem_rdata;
        p_stall  = pipe_req;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet while reset is held, which also drops any in-flight read.
    if (!rst_n) begin
      state_d   = IDLE;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      p_rdata   = '0;
      d_rdata   = '0;
      p_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      p_stall   = 1'b0;
      d_ack     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_MAX));

  // Counts IDLE cycles in which DMA asked but lost; saturates at STARVE_MAX.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (d_ack) begin
      starve_cnt_d = '0;
    end else if (state_q == IDLE && bus.d_req && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.p_rdata   = p_rdata;
  assign bus.d_rdata   = d_rdata;
  assign bus.p_rvalid  = p_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.p_stall   = p_stall;
  assign bus.d_ack     = d_ack;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.p_rd && bus.p_wr))
        else $error("dmem_arbiter: p_rd and p_wr asserted together");
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
// Starvation expectations follow DMEM_ARB_STARVE_EN (STARVE_MAX = 8).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:4095];

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Applies one cycle of stimulus just after the falling edge, then settles before checks.
  task automatic drive(input logic rst, input logic prd, input logic pwr,
                       input logic [11:0] pa, input logic [31:0] pd,
                       input logic dreq, input logic dwe,
                       input logic [11:0] da, input logic [31:0] dd);
    @(negedge clk);
    rst_n       = rst;
    bus.p_rd    = prd;
    bus.p_wr    = pwr;
    bus.p_addr  = pa;
    bus.p_wdata = pd;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dd;
    #1;
  endtask

  logic exp_starve;

  initial begin
    // Reset held two cycles with every request asserted
    drive(1'b0, 1'b1, 1'b1, 12'h05A, 32'h1111_1111, 1'b1, 1'b1, 12'h0AA, 32'h2222_2222);
    check("rst1_mem_we",   32'(bus.mem_we),   32'd0);
    check("rst1_mem_re",   32'(bus.mem_re),   32'd0);
    check("rst1_p_stall",  32'(bus.p_stall),  32'd0);
    check("rst1_d_ack",    32'(bus.d_ack),    32'd0);
    drive(1'b0, 1'b1, 1'b1, 12'h05A, 32'h1111_1111, 1'b1, 1'b1, 12'h0AA, 32'h2222_2222);
    check("rst2_p_rvalid", 32'(bus.p_rvalid), 32'd0);
    check("rst2_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rst2_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst2_mem_wdata", bus.mem_wdata,    32'd0);

    // First cycle after release: pipeline write granted with no stall
    drive(1'b1, 1'b0, 1'b1, 12'h05A, 32'hDEAD_BEEF, 1'b0, 1'b0, 12'h000, 32'h0);
    check("pw_mem_we",    32'(bus.mem_we),   32'd1);
    check("pw_mem_re",    32'(bus.mem_re),   32'd0);
    check("pw_mem_addr",  32'(bus.mem_addr), 32'h05A);
    check("pw_mem_wdata", bus.mem_wdata,     32'hDEAD_BEEF);
    check("pw_p_stall",   32'(bus.p_stall),  32'd0);

    // Pipeline read: stall in the issue cycle, data the next cycle
    drive(1'b1, 1'b1, 1'b0, 12'h05A, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    check("pr_mem_re",    32'(bus.mem_re),   32'd1);
    check("pr_p_stall",   32'(bus.p_stall),  32'd1);
    check("pr_p_rvalid",  32'(bus.p_rvalid), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 12'h05A, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    check("prd_p_rvalid", 32'(bus.p_rvalid), 32'd1);
    check("prd_p_rdata",  bus.p_rdata,       32'hDEAD_BEEF);
    check("prd_p_stall",  32'(bus.p_stall),  32'd0);
    check("prd_mem_re",   32'(bus.mem_re),   32'd0);

    // Preload 0x100 for the DMA read
    drive(1'b1, 1'b0, 1'b1, 12'h100, 32'hCAFE_F00D, 1'b0, 1'b0, 12'h000, 32'h0);
    check("pre_mem_we", 32'(bus.mem_we), 32'd1);

    // Contention: pipeline read wins, DMA read of 0x100 waits
    drive(1'b1, 1'b1, 1'b0, 12'h05A, 32'h0, 1'b1, 1'b0, 12'h100, 32'h0);
    check("ct_d_ack",    32'(bus.d_ack),    32'd0);
    check("ct_p_stall",  32'(bus.p_stall),  32'd1);
    check("ct_mem_addr", 32'(bus.mem_addr), 32'h05A);
    drive(1'b1, 1'b1, 1'b0, 12'h05A, 32'h0, 1'b1, 1'b0, 12'h100, 32'h0);
    check("ct_p_rvalid", 32'(bus.p_rvalid), 32'd1);
    check("ct_p_rdata",  bus.p_rdata,       32'hDEAD_BEEF);
    check("ct_d_ack_rd", 32'(bus.d_ack),    32'd0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h100, 32'h0);
    check("ct_d_ack_late", 32'(bus.d_ack),    32'd1);
    check("ct_d_mem_re",   32'(bus.mem_re),   32'd1);
    check("ct_d_mem_addr", 32'(bus.mem_addr), 32'h100);
    // RD_D: DMA data returns; a pipeline write arriving now must stall
    drive(1'b1, 1'b0, 1'b1, 12'h200, 32'h5555_AAAA, 1'b0, 1'b0, 12'h000, 32'h0);
    check("rdd_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("rdd_d_rdata",  bus.d_rdata,       32'hCAFE_F00D);
    check("rdd_p_stall",  32'(bus.p_stall),  32'd1);
    check("rdd_mem_we",   32'(bus.mem_we),   32'd0);
    drive(1'b1, 1'b0, 1'b1, 12'h200, 32'h5555_AAAA, 1'b0, 1'b0, 12'h000, 32'h0);
    check("after_rdd_mem_we",  32'(bus.mem_we),  32'd1);
    check("after_rdd_p_stall", 32'(bus.p_stall), 32'd0);

    // DMA write to the top address while the pipeline is idle
    drive(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'hFFF, 32'h1234_5678);
    check("dw_d_ack",    32'(bus.d_ack),    32'd1);
    check("dw_mem_we",   32'(bus.mem_we),   32'd1);
    check("dw_mem_addr", 32'(bus.mem_addr), 32'hFFF);
    check("dw_mem_wdata", bus.mem_wdata,    32'h1234_5678);
    drive(1'b1, 1'b1, 1'b0, 12'hFFF, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    check("dw_rb_mem_re", 32'(bus.mem_re), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 12'hFFF, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    check("dw_rb_p_rvalid", 32'(bus.p_rvalid), 32'd1);
    check("dw_rb_p_rdata",  bus.p_rdata,       32'h1234_5678);

    // Back-to-back pipeline writes with DMA write pending
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b1, 12'(12'h400 + i), 32'(i), 1'b1, 1'b1, 12'h300, 32'hABCD_0000);
`ifdef DMEM_ARB_STARVE_EN
      exp_starve = (i == 8);
`else
      exp_starve = 1'b0;
`endif
      check($sformatf("starve_d_ack_%0d", i),   32'(bus.d_ack),   32'(exp_starve));
      check($sformatf("starve_p_stall_%0d", i), 32'(bus.p_stall), 32'(exp_starve));
    end

    // Reset asserted while a DMA read sits in RD_D
    drive(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h100, 32'h0);
    check("mr_d_ack", 32'(bus.d_ack), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    check("mr_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("mr_mem_re",   32'(bus.mem_re),   32'd0);
    check("mr_mem_we",   32'(bus.mem_we),   32'd0);
    drive(1'b1, 1'b0, 1'b1, 12'h010, 32'h0BAD_CAFE, 1'b0, 1'b0, 12'h000, 32'h0);
    check("mr_after_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("mr_after_p_stall",  32'(bus.p_stall),  32'd0);
    check("mr_after_mem_we",   32'(bus.mem_we),   32'd1);

    drive(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
